// File: rtl/packet_fifo_pkg.sv
// Shared defaults, pointer-width helper and per-cycle operation encoding for packet_fifo.
package packet_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 64;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_FLUSH,
        OP_DISCARD,
        OP_NORMAL
    } op_e;

    // Pointer carries one extra MSB so full and empty are distinguishable.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/packet_fifo_mem.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
module packet_fifo_mem
    import packet_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Array is deliberately unreset; only the read register has a defined reset value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Read sees pre-write contents, so a read and write to one entry at full is safe.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/packet_fifo.sv
// Synchronous FIFO with sticky errors and registered read port.
// Define PACKET_FIFO_ROLLBACK_EN to enable packet commit/discard staging.
module packet_fifo
    import packet_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       occupancy,
    output logic              full,
    output logic              empty,
    output logic              overflow_err,
    output logic              underflow_err,
    input  logic              pkt_commit,
    input  logic              pkt_discard
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full_w, empty_w;
    logic          rd_acc, wr_acc;
    op_e           op;

`ifdef PACKET_FIFO_ROLLBACK_EN
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    assign commit_ptr = commit_ptr_q;
`else
    logic unused_pkt;
    assign commit_ptr = wr_ptr_q;
    assign unused_pkt = pkt_discard;
`endif

    // Reader only sees published words; staged words still consume space.
    assign empty_w = (commit_ptr == rd_ptr_q);
    assign full_w  = (PW'(wr_ptr_q - rd_ptr_q) == PW'(DEPTH));

    always_comb begin
        op = OP_NORMAL;
        if (clear) begin
            op = OP_CLEAR;
        end else if (flush) begin
            op = OP_FLUSH;
`ifdef PACKET_FIFO_ROLLBACK_EN
        end else if (pkt_discard) begin
            op = OP_DISCARD;
`endif
        end else if (!wr_en && !rd_en && !pkt_commit) begin
            op = OP_NONE;
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
`ifdef PACKET_FIFO_ROLLBACK_EN
        commit_ptr_d = commit_ptr_q;
`endif
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        case (op)
            OP_CLEAR: begin
                rd_ptr_d    = '0;
                wr_ptr_d    = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
`ifdef PACKET_FIFO_ROLLBACK_EN
                commit_ptr_d = '0;
`endif
            end
            OP_FLUSH: begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
`ifdef PACKET_FIFO_ROLLBACK_EN
                commit_ptr_d = '0;
`endif
            end
            OP_DISCARD: begin
                // Reads of published data continue; the staged packet and any new word are dropped.
                rd_acc      = rd_en && !empty_w;
                underflow_d = underflow_q | (rd_en & empty_w);
                wr_ptr_d    = commit_ptr;
            end
            OP_NORMAL: begin
                rd_acc      = rd_en && !empty_w;
                wr_acc      = wr_en && (!full_w || rd_acc);
                underflow_d = underflow_q | (rd_en & empty_w);
                overflow_d  = overflow_q | (wr_en & !wr_acc);
                if (wr_acc) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
`ifdef PACKET_FIFO_ROLLBACK_EN
                if (pkt_commit) begin
                    commit_ptr_d = wr_ptr_d;
                end
`endif
            end
            default: ;
        endcase
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef PACKET_FIFO_ROLLBACK_EN
            commit_ptr_q <= '0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef PACKET_FIFO_ROLLBACK_EN
            commit_ptr_q <= commit_ptr_d;
`endif
        end
    end

    packet_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_idx  (wr_ptr_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_idx  (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign rd_valid      = rd_valid_q;
    assign occupancy     = commit_ptr - rd_ptr_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: DEPTH=4 and DEPTH=64 instances share stimulus and are checked against a queue model.
module tb_packet_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic       pkt_commit = 1'b0, pkt_discard = 1'b0;
    logic [7:0] wr_data = '0;

    logic [7:0] rd_data4, rd_data64;
    logic       rd_valid4, rd_valid64, full4, full64, empty4, empty64;
    logic       ovf4, ovf64, udf4, udf64;
    logic [2:0] occ4;
    logic [6:0] occ64;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    packet_fifo #(.DATA_W(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .clear(clear), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .occupancy(occ4),
        .full(full4), .empty(empty4), .overflow_err(ovf4), .underflow_err(udf4),
        .pkt_commit(pkt_commit), .pkt_discard(pkt_discard)
    );

    packet_fifo #(.DATA_W(8), .DEPTH(64)) u64 (
        .clk(clk), .rst(rst), .clear(clear), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data64), .rd_valid(rd_valid64), .occupancy(occ64),
        .full(full64), .empty(empty64), .overflow_err(ovf64), .underflow_err(udf64),
        .pkt_commit(pkt_commit), .pkt_discard(pkt_discard)
    );

    // Reference model: published words, staged words, last popped word, sticky flags.
    int unsigned m_depth [2] = '{4, 64};
    logic [7:0]  m_q   [2][$];
    logic [7:0]  m_stg [2][$];
    logic [7:0]  m_data  [2];
    bit          m_valid [2];
    bit          m_ovf   [2];
    bit          m_udf   [2];

    task automatic model_step(input int m);
        bit do_rd, do_wr, full_m;
        if (clear || flush) begin
            m_q[m].delete();
            m_stg[m].delete();
            m_valid[m] = 1'b0;
            if (clear) begin
                m_ovf[m] = 1'b0;
                m_udf[m] = 1'b0;
            end
        end else begin
            do_rd  = rd_en && (m_q[m].size() != 0);
            full_m = (m_q[m].size() + m_stg[m].size()) == m_depth[m];
            do_wr  = 1'b0;
`ifdef PACKET_FIFO_ROLLBACK_EN
            if (pkt_discard) begin
                m_stg[m].delete();
            end else
`endif
            begin
                do_wr = wr_en && (!full_m || do_rd);
                if (wr_en && !do_wr) m_ovf[m] = 1'b1;
            end
            if (rd_en && !do_rd) m_udf[m] = 1'b1;
            m_valid[m] = do_rd;
            if (do_rd) m_data[m] = m_q[m].pop_front();
`ifdef PACKET_FIFO_ROLLBACK_EN
            if (do_wr) m_stg[m].push_back(wr_data);
            if (pkt_commit && !pkt_discard) begin
                while (m_stg[m].size() != 0) m_q[m].push_back(m_stg[m].pop_front());
            end
`else
            if (do_wr) m_q[m].push_back(wr_data);
`endif
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_q[m].delete();
                m_stg[m].delete();
                m_data[m]  = '0;
                m_valid[m] = 1'b0;
                m_ovf[m]   = 1'b0;
                m_udf[m]   = 1'b0;
            end else begin
                model_step(m);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int m, input logic [7:0] rdd, input logic rdv, input logic [31:0] occ,
                           input logic fu, input logic em, input logic ov, input logic un);
        string tag;
        tag = $sformatf("u%0d", m_depth[m]);
        chk({tag, ".rd_valid"},  32'(rdv), 32'(m_valid[m]));
        chk({tag, ".rd_data"},   32'(rdd), 32'(m_data[m]));
        chk({tag, ".occupancy"}, occ, 32'(m_q[m].size()));
        chk({tag, ".full"},      32'(fu), 32'((m_q[m].size() + m_stg[m].size()) == m_depth[m]));
        chk({tag, ".empty"},     32'(em), 32'(m_q[m].size() == 0));
        chk({tag, ".overflow"},  32'(ov), 32'(m_ovf[m]));
        chk({tag, ".underflow"}, 32'(un), 32'(m_udf[m]));
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp_dut(0, rd_data4,  rd_valid4,  32'(occ4),  full4,  empty4,  ovf4,  udf4);
            cmp_dut(1, rd_data64, rd_valid64, 32'(occ64), full64, empty64, ovf64, udf64);
        end
    end

    task automatic drive(input logic we, input logic [7:0] wd, input logic re,
                         input logic cm, input logic dc, input logic cl, input logic fl);
        wr_en = we; wr_data = wd; rd_en = re;
        pkt_commit = cm; pkt_discard = dc; clear = cl; flush = fl;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; pkt_commit = 1'b0; pkt_discard = 1'b0;
        clear = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d); drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic rd();                    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic idle();                  drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        chk("reset.empty",    32'(empty64),    32'd1);
        chk("reset.rd_valid", 32'(rd_valid64), 32'd0);
        chk("reset.occ",      32'(occ64),      32'd0);
        chk("reset.rd_data",  32'(rd_data64),  32'd0);

        // Basic ordering and latency
        wr(8'hA1); chk("wr1.occ", 32'(occ64), 32'd1); chk("wr1.empty", 32'(empty64), 32'd0);
        wr(8'hA2); wr(8'hA3);
        chk("wr3.occ", 32'(occ64), 32'd3);
        rd(); chk("rd1.valid", 32'(rd_valid64), 32'd1); chk("rd1.data", 32'(rd_data64), 32'hA1);
        rd(); chk("rd2.data", 32'(rd_data64), 32'hA2);
        rd(); chk("rd3.data", 32'(rd_data64), 32'hA3); chk("rd3.occ", 32'(occ64), 32'd0);
        chk("rd3.empty", 32'(empty64), 32'd1);
        idle(); chk("idle.valid", 32'(rd_valid64), 32'd0); chk("idle.hold", 32'(rd_data64), 32'hA3);

        // Full / overflow on the 4-deep instance
        for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
        chk("d4.full", 32'(full4), 32'd1); chk("d4.occ", 32'(occ4), 32'd4); chk("d64.notfull", 32'(full64), 32'd0);
        wr(8'h14);
        chk("d4.ovf", 32'(ovf4), 32'd1); chk("d4.occ_after_drop", 32'(occ4), 32'd4); chk("d64.noovf", 32'(ovf64), 32'd0);
        drive(1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("d4.rw_full.occ", 32'(occ4), 32'd4); chk("d4.rw_full.data", 32'(rd_data4), 32'h10);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear.ovf", 32'(ovf4), 32'd0); chk("clear.occ", 32'(occ4), 32'd0);

        // Read while empty with a same-cycle write
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("uf.valid", 32'(rd_valid64), 32'd0); chk("uf.err", 32'(udf64), 32'd1); chk("uf.occ", 32'(occ64), 32'd1);
        rd(); chk("uf.next", 32'(rd_data64), 32'h55);

        // Flush keeps errors, clear drops them
        wr(8'h66);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush.occ", 32'(occ64), 32'd0); chk("flush.udf_kept", 32'(udf64), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear.udf", 32'(udf64), 32'd0);

        // 70 words through the 64-deep instance: pointer wrap
        for (int i = 0; i < 73; i++) begin
            drive(i < 70, 8'(8'h20 + i), i >= 3, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("wrap.ovf", 32'(ovf64), 32'd0); chk("wrap.udf", 32'(udf64), 32'd0);
        chk("wrap.occ", 32'(occ64), 32'd0); chk("wrap.last", 32'(rd_data64), 32'h65);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PACKET_FIFO_ROLLBACK_EN
        wr(8'h01); wr(8'h02);
        chk("rb.staged_occ", 32'(occ64), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wr(8'h03); wr(8'h04); wr(8'h05);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rb.discard_occ", 32'(occ64), 32'd2);
        rd(); chk("rb.rd1", 32'(rd_data64), 32'h01);
        rd(); chk("rb.rd2", 32'(rd_data64), 32'h02);
        chk("rb.empty", 32'(empty64), 32'd1);
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rb.wr_commit_occ", 32'(occ64), 32'd1);
        rd(); chk("rb.wr_commit_data", 32'(rd_data64), 32'h77);
`else
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("norb.discard_ignored", 32'(occ64), 32'd1);
        rd(); chk("norb.data", 32'(rd_data64), 32'h33);
`endif

        // Randomised traffic, filling phase then draining phase
        for (int i = 0; i < 2000; i++) begin
            int wp, rp;
            wp = (i < 1000) ? 70 : 40;
            rp = (i < 1000) ? 40 : 65;
            drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
        end

        // Reset mid-stream: outputs return to reset values immediately
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wr(8'hC3); wr(8'hC4);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst.data", 32'(rd_data64), 32'hC3);
        rst = 1'b1;
        #1;
        chk("rst.rd_data",  32'(rd_data64), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid64), 32'd0);
        chk("rst.occ",      32'(occ64), 32'd0);
        chk("rst.empty",    32'(empty64), 32'd1);
        chk("rst.full4",    32'(full4), 32'd0);
        chk("rst.ovf4",     32'(ovf4), 32'd0);
        chk("rst.udf64",    32'(udf64), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
